// File: rtl/hex_ascii_streamer_pkg.sv
// Shared definitions for the hex-to-ASCII transmit streamer: FSM states,
// character constants and a sizing helper for the nibble counter.
package hex_ascii_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_CR   = 3'd2,
    ST_LF   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_UA   = 8'h41;
  localparam logic [7:0] ASCII_LA   = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Counter must hold NIBBLES-1; keep at least one bit for the single-digit case.
  function automatic int cnt_width(input int nibbles);
    if (nibbles > 1) begin
      return $clog2(nibbles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/hex_ascii_streamer_enc.sv
// Combinational nibble-to-ASCII encoder; inverse of the ASCII-to-hex decoder.
module hex_ascii_enc
  import hex_ascii_streamer_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Decimal digits from '0', letters from 'A' or 'a' depending on case.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else if (UPPER) begin
      ascii = ASCII_UA + {4'h0, nibble - 4'd10};
    end else begin
      ascii = ASCII_LA + {4'h0, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Streams a parallel word as ASCII hex digits (MSB nibble first), optionally
// followed by CR LF, over a valid/ready handshake towards the UART transmitter.
module hex_ascii_streamer
  import hex_ascii_streamer_pkg::*;
#(
  parameter int NIBBLES     = 4,
  parameter bit UPPER       = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] DATA_IN,
  input  logic                 START,
  output logic                 BUSY,
  output logic [7:0]           ASCII_OUT,
  output logic                 ASCII_VLD,
  input  logic                 ASCII_RDY,
  output logic                 DONE
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIBBLES - 1);

  state_t          state_r;
  logic [W-1:0]    shift_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      ascii_r;
  logic            vld_r;
  logic            busy_r;
  logic            done_r;

  logic [W-1:0]    shift_next_s;
  logic [3:0]      enc_nib_s;
  logic [7:0]      enc_char_s;
  logic            xfer_s;

  // The encoder sees the word's top nibble when starting, otherwise the digit after the current one.
  always_comb begin
    shift_next_s = shift_r << 3'd4;
    xfer_s       = vld_r & ASCII_RDY;
    if (state_r == ST_IDLE) begin
      enc_nib_s = DATA_IN[W-1 -: 4];
    end else begin
      enc_nib_s = shift_next_s[W-1 -: 4];
    end
  end

  hex_ascii_enc #(
    .UPPER (UPPER)
  ) u_enc (
    .nibble (enc_nib_s),
    .ascii  (enc_char_s)
  );

  // Transmit FSM with shift register, digit counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      ascii_r <= 8'h00;
      vld_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (START) begin
            shift_r <= DATA_IN;
            cnt_r   <= CNT_LOAD;
            ascii_r <= enc_char_s;
            vld_r   <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            if (cnt_r != '0) begin
              shift_r <= shift_next_s;
              cnt_r   <= cnt_r - 1'b1;
              ascii_r <= enc_char_s;
            end else if (APPEND_CRLF) begin
              ascii_r <= ASCII_CR;
              state_r <= ST_CR;
            end else begin
              vld_r   <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end
          end
        end
        ST_CR: begin
          if (xfer_s) begin
            ascii_r <= ASCII_LF;
            state_r <= ST_LF;
          end
        end
        ST_LF: begin
          if (xfer_s) begin
            vld_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          // START is deliberately not looked at here; the next word may begin from IDLE.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          vld_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_r;
  assign ASCII_OUT = ascii_r;
  assign ASCII_VLD = vld_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer: several parameterisations share one
// clock and reset; each scenario task checks its own expected characters.
module tb_hex_ascii_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // main instance: 4 digits, upper case, CR LF
  logic [15:0] m_data = 16'h0;
  logic m_start = 1'b0, m_rdy = 1'b0;
  logic m_busy, m_vld, m_done;
  logic [7:0] m_out;
  // lower-case instance
  logic [15:0] l_data = 16'h0;
  logic l_start = 1'b0, l_rdy = 1'b0;
  logic l_busy, l_vld, l_done;
  logic [7:0] l_out;
  // single-digit loopback instances, upper (a) and lower (b)
  logic [3:0] a_data = 4'h0, b_data = 4'h0;
  logic a_start = 1'b0, a_rdy = 1'b0, b_start = 1'b0, b_rdy = 1'b0;
  logic a_busy, a_vld, a_done, b_busy, b_vld, b_done;
  logic [7:0] a_out, b_out;

  hex_ascii_streamer #(.NIBBLES(4), .UPPER(1'b1), .APPEND_CRLF(1'b1)) dut_m (
    .clk(clk), .rst(rst), .DATA_IN(m_data), .START(m_start), .BUSY(m_busy),
    .ASCII_OUT(m_out), .ASCII_VLD(m_vld), .ASCII_RDY(m_rdy), .DONE(m_done));

  hex_ascii_streamer #(.NIBBLES(4), .UPPER(1'b0), .APPEND_CRLF(1'b1)) dut_l (
    .clk(clk), .rst(rst), .DATA_IN(l_data), .START(l_start), .BUSY(l_busy),
    .ASCII_OUT(l_out), .ASCII_VLD(l_vld), .ASCII_RDY(l_rdy), .DONE(l_done));

  hex_ascii_streamer #(.NIBBLES(1), .UPPER(1'b1), .APPEND_CRLF(1'b0)) dut_a (
    .clk(clk), .rst(rst), .DATA_IN(a_data), .START(a_start), .BUSY(a_busy),
    .ASCII_OUT(a_out), .ASCII_VLD(a_vld), .ASCII_RDY(a_rdy), .DONE(a_done));

  hex_ascii_streamer #(.NIBBLES(1), .UPPER(1'b0), .APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .DATA_IN(b_data), .START(b_start), .BUSY(b_busy),
    .ASCII_OUT(b_out), .ASCII_VLD(b_vld), .ASCII_RDY(b_rdy), .DONE(b_done));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ASCII-to-hex decoder model: {HEX_FLG, nibble}
  function automatic logic [4:0] dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    else return 5'h00;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++; if (m_vld !== 1'b0) $display("FAIL reset_vld got=%b want=0", m_vld); else passed++;
    total++; if (m_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", m_busy); else passed++;
    total++; if (m_done !== 1'b0) $display("FAIL reset_done got=%b want=0", m_done); else passed++;
    total++; if (m_out !== 8'h00) $display("FAIL reset_out got=%h want=00", m_out); else passed++;
    rst = 1'b0;
    tick;
    total++; if (m_vld !== 1'b0 || m_busy !== 1'b0) $display("FAIL reset_idle vld=%b busy=%b want=0,0", m_vld, m_busy); else passed++;
  endtask

  task automatic test_basic;
    logic [7:0] want [6];
    want = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    m_data = 16'h1A3F; m_start = 1'b1; m_rdy = 1'b1;
    tick;
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (m_vld !== 1'b1 || m_out !== want[i]) $display("FAIL basic_char%0d vld=%b got=%h want=%h", i, m_vld, m_out, want[i]); else passed++;
      total++; if (m_busy !== 1'b1 || m_done !== 1'b0) $display("FAIL basic_busy%0d busy=%b done=%b want=1,0", i, m_busy, m_done); else passed++;
      tick;
    end
    total++; if (m_done !== 1'b1 || m_vld !== 1'b0 || m_busy !== 1'b1) $display("FAIL basic_fin done=%b vld=%b busy=%b want=1,0,1", m_done, m_vld, m_busy); else passed++;
    tick;
    total++; if (m_done !== 1'b0 || m_busy !== 1'b0) $display("FAIL basic_idle done=%b busy=%b want=0,0", m_done, m_busy); else passed++;
  endtask

  task automatic test_lower;
    logic [7:0] want [6];
    want = '{8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
    l_data = 16'hBEEF; l_start = 1'b1; l_rdy = 1'b1;
    tick;
    l_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (l_vld !== 1'b1 || l_out !== want[i]) $display("FAIL lower_char%0d vld=%b got=%h want=%h", i, l_vld, l_out, want[i]); else passed++;
      tick;
    end
    total++; if (l_done !== 1'b1 || l_vld !== 1'b0) $display("FAIL lower_fin done=%b vld=%b want=1,0", l_done, l_vld); else passed++;
    tick;
    total++; if (l_busy !== 1'b0) $display("FAIL lower_idle busy=%b want=0", l_busy); else passed++;
  endtask

  task automatic test_backpressure;
    logic [7:0] want [6];
    want = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
    m_data = 16'h0009; m_start = 1'b1; m_rdy = 1'b0;
    tick;
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 3; p++) begin
        m_rdy = (p == 2);
        total++; if (m_vld !== 1'b1 || m_out !== want[i]) $display("FAIL bp_char%0d_%0d vld=%b got=%h want=%h", i, p, m_vld, m_out, want[i]); else passed++;
        tick;
      end
    end
    m_rdy = 1'b0;
    total++; if (m_done !== 1'b1 || m_vld !== 1'b0) $display("FAIL bp_fin done=%b vld=%b want=1,0", m_done, m_vld); else passed++;
    tick;
    total++; if (m_done !== 1'b0 || m_busy !== 1'b0) $display("FAIL bp_idle done=%b busy=%b want=0,0", m_done, m_busy); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1 [6];
    logic [7:0] w2 [6];
    w1 = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    w2 = '{8'h43, 8'h30, 8'h44, 8'h45, 8'h0D, 8'h0A};
    m_data = 16'h1A3F; m_start = 1'b1; m_rdy = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        m_start = 1'b1; m_data = 16'h5555;
      end else begin
        m_start = 1'b0;
      end
      total++; if (m_vld !== 1'b1 || m_out !== w1[i]) $display("FAIL b2b_first%0d vld=%b got=%h want=%h", i, m_vld, m_out, w1[i]); else passed++;
      tick;
    end
    total++; if (m_done !== 1'b1) $display("FAIL b2b_fin done=%b want=1", m_done); else passed++;
    m_start = 1'b1; m_data = 16'h7777;
    tick;
    total++; if (m_vld !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) $display("FAIL b2b_idle vld=%b busy=%b done=%b want=0,0,0", m_vld, m_busy, m_done); else passed++;
    m_data = 16'hC0DE;
    tick;
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (m_vld !== 1'b1 || m_out !== w2[i] || m_busy !== 1'b1) $display("FAIL b2b_second%0d vld=%b busy=%b got=%h want=%h", i, m_vld, m_busy, m_out, w2[i]); else passed++;
      tick;
    end
    total++; if (m_done !== 1'b1) $display("FAIL b2b_fin2 done=%b want=1", m_done); else passed++;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [7:0] want [6];
    want = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    m_data = 16'hFFFF; m_start = 1'b1; m_rdy = 1'b1;
    tick;
    m_start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    total++; if (m_vld !== 1'b1 || m_out !== 8'h0A) $display("FAIL rst_lf_pending vld=%b got=%h want=0a", m_vld, m_out); else passed++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (m_vld !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) $display("FAIL rst_mid vld=%b busy=%b done=%b want=0,0,0", m_vld, m_busy, m_done); else passed++;
    tick;
    total++; if (m_vld !== 1'b0 || m_done !== 1'b0) $display("FAIL rst_quiet vld=%b done=%b want=0,0", m_vld, m_done); else passed++;
    m_start = 1'b1;
    tick;
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (m_vld !== 1'b1 || m_out !== want[i]) $display("FAIL rst_resend%0d vld=%b got=%h want=%h", i, m_vld, m_out, want[i]); else passed++;
      tick;
    end
    total++; if (m_done !== 1'b1) $display("FAIL rst_resend_fin done=%b want=1", m_done); else passed++;
    tick;
  endtask

  task automatic test_loopback;
    logic [7:0] wu, wl;
    logic [4:0] du, dl;
    a_rdy = 1'b1; b_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      wu = (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
      wl = (n < 10) ? 8'(8'h30 + n) : 8'(8'h61 + n - 10);
      a_data = n[3:0]; b_data = n[3:0];
      a_start = 1'b1; b_start = 1'b1;
      tick;
      a_start = 1'b0; b_start = 1'b0;
      du = dec(a_out); dl = dec(b_out);
      total++; if (a_vld !== 1'b1 || a_out !== wu) $display("FAIL lb_upper%0d vld=%b got=%h want=%h", n, a_vld, a_out, wu); else passed++;
      total++; if (b_vld !== 1'b1 || b_out !== wl) $display("FAIL lb_lower%0d vld=%b got=%h want=%h", n, b_vld, b_out, wl); else passed++;
      total++; if (du !== {1'b1, n[3:0]}) $display("FAIL lb_dec_upper%0d got=%h want=%h", n, du, {1'b1, n[3:0]}); else passed++;
      total++; if (dl !== {1'b1, n[3:0]}) $display("FAIL lb_dec_lower%0d got=%h want=%h", n, dl, {1'b1, n[3:0]}); else passed++;
      tick;
      total++; if (a_done !== 1'b1 || b_done !== 1'b1 || a_vld !== 1'b0) $display("FAIL lb_done%0d a=%b b=%b vld=%b want=1,1,0", n, a_done, b_done, a_vld); else passed++;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lower;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_ascii_streamer.md
Name: hex_ascii_streamer

Overview:
Transmit-side counterpart of the ASCII-to-hex decoder. Converts a parallel data word into a stream of ASCII hex characters, most significant nibble first, optionally terminated by CR LF. Hands characters one at a time to the UART transmitter over a valid/ready handshake. Sits between the controller datapath and the UART TX block.

Parameters:
NIBBLES, 4, number of hex digits per word; 1..8; DATA_IN width is 4*NIBBLES.
UPPER, 1, 1 = digits A-F encoded 8'h41-8'h46; 0 = a-f encoded 8'h61-8'h66.
APPEND_CRLF, 1, 1 = emit 8'h0D then 8'h0A after the last digit; 0 = no terminator.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
DATA_IN  in  4*NIBBLES  word to transmit; sampled only when START is accepted.
START  in  1  request to send DATA_IN; accepted only in IDLE.
BUSY  out  1  high from the cycle after START is accepted until DONE is asserted, inclusive.
ASCII_OUT  out  8  current character.
ASCII_VLD  out  1  ASCII_OUT holds a valid character.
ASCII_RDY  in  1  UART TX accepts the character this cycle.
DONE  out  1  one-cycle pulse after the final character is accepted.

Behaviour:
- Reset: state IDLE; ASCII_OUT=8'h00, ASCII_VLD=0, BUSY=0, DONE=0; shift register and counter cleared. rst overrides all other inputs in every state. Reset mid-word abandons the word and emits no further characters.
- A transfer occurs on any rising edge with ASCII_VLD=1 and ASCII_RDY=1.
- IDLE:
  - START=1 latches DATA_IN into the shift register and loads the nibble counter with NIBBLES-1.
  - Next cycle: state SEND, BUSY=1, ASCII_VLD=1, ASCII_OUT=encode(top nibble). Latency from START to first valid character is 1 cycle.
  - START in any other state is ignored, and DATA_IN is not resampled.
- SEND:
  - ASCII_OUT and ASCII_VLD stay stable while ASCII_RDY=0.
  - On a transfer with counter>0: shift the register left by 4, decrement the counter, and present the next digit the following cycle. VLD stays high, giving back-to-back transfers at one character per cycle when RDY is held high.
  - On a transfer with counter=0: go to CR if APPEND_CRLF=1, otherwise to FIN.
- CR: ASCII_OUT=8'h0D, VLD=1; on transfer go to LF.
- LF: ASCII_OUT=8'h0A, VLD=1; on transfer go to FIN.
- FIN: VLD=0, DONE=1 for exactly one cycle, BUSY=1; next state IDLE. BUSY falls the cycle after DONE.
  - START asserted during FIN is ignored.
  - START in the first IDLE cycle is accepted, so the minimum gap between words is 2 cycles.
- Encoding: nibble 0-9 maps to 8'h30+n. Nibble 10-15 maps to 8'h41+(n-10) when UPPER=1, or 8'h61+(n-10) when UPPER=0. Purely combinational and registered into ASCII_OUT.
- When VLD=0, ASCII_OUT holds its last value; consumers must not use it.
- ASCII_RDY is a don't-care when ASCII_VLD=0.
- Characters per word: NIBBLES + 2*APPEND_CRLF.

Decomposition:
- Shared package: state encoding (IDLE, SEND, CR, LF, FIN) and character constants (ASCII_ZERO 8'h30, ASCII_UA 8'h41, ASCII_LA 8'h61, ASCII_CR 8'h0D, ASCII_LF 8'h0A).
- One combinational sub-module, hex_ascii_enc (4-bit nibble plus UPPER parameter to 8-bit char). It is the inverse of the decoder and is tested against it in a loopback.
- FSM, shift register and counter live in the top module.

Test Plan:
- Reset, then START with DATA_IN=16'h1A3F and RDY held high: characters 31,41,33,46,0D,0A on consecutive cycles; DONE on the cycle after 0A; BUSY low one cycle later.
- UPPER=0, DATA_IN=16'hBEEF: characters 62,65,65,66,0D,0A.
- Backpressure: DATA_IN=16'h0009 with RDY toggling 0,0,1 repeatedly. Each character stays stable through its RDY=0 cycles, the sequence is 30,30,30,39,0D,0A, and no character is duplicated or dropped.
- START pulsed again during SEND and during FIN with a different DATA_IN: ignored, and the original word completes unchanged. START in the first IDLE cycle after FIN starts the new word one cycle later.
- rst asserted while LF is pending: next cycle VLD=0, BUSY=0, DONE=0, state IDLE; a following START with 16'hFFFF sends 46,46,46,46,0D,0A cleanly.
- Exhaustive loopback with NIBBLES=1, APPEND_CRLF=0, for all nibbles 0-F with both UPPER settings: each output passed through the ASCII-to-hex decoder returns the original nibble with HEX_FLG=1.
